// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 field layout, constants and operand classification
// shared by the FP32 multiplier and divider.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP32_BIAS    = 127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_INF_EXP = 8'hFF;

    typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp32_class_t;

    typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_DIVZ, SP_INF, SP_ZERO} fp32_special_t;

    // Subnormals classify as zero so they flush like the multiplier does.
    function automatic fp32_class_t fp32_class(input fp32_t x);
        return x.exp == 8'd0 ? FP_ZERO :
               x.exp != FP32_INF_EXP ? FP_NORMAL :
               x.frac == 23'd0 ? FP_INF : FP_NAN;
    endfunction

endpackage

// File: rtl/fp32_div_special.sv
// fp32_div_special: picks which special-case result overrides the computed
// quotient, in priority order, plus the quotient sign.
module fp32_div_special
    import fp32_pkg::*;
(
    input  fp32_t         a,
    input  fp32_t         b,
    output fp32_special_t sel,
    output logic          sign
);

    fp32_class_t ca, cb;

    always_comb begin
        ca   = fp32_class(a);
        cb   = fp32_class(b);
        sign = a.sign ^ b.sign;
        sel  = (ca == FP_NAN || cb == FP_NAN ||
                (ca == FP_ZERO && cb == FP_ZERO) ||
                (ca == FP_INF && cb == FP_INF)) ? SP_NAN :
               cb == FP_ZERO ? SP_DIVZ :
               ca == FP_INF ? SP_INF :
               (cb == FP_INF || ca == FP_ZERO) ? SP_ZERO : SP_NONE;
    end

endmodule

// File: rtl/fp32_div_iterative.sv
// fp32_div_iterative: binary32 divider, one restoring quotient bit per cycle,
// truncating, flush-to-zero; fixed 26-cycle latency from accept to done.
module fp32_div_iterative
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM} state_t;

    state_t              state, state_nxt;
    fp32_t               opa, opb;
    logic [25:0]         rem, rem_sel;
    logic [23:0]         dvs;
    logic [24:0]         q;
    logic [4:0]          cnt;
    logic [26:0]         diff;
    logic                ge;
    logic signed [9:0]   exp_q;
    logic [22:0]         frac_q;
    fp32_special_t       sel;
    logic                sign;
    logic [31:0]         res_nxt;
    logic                dz_nxt, inv_nxt, ov_nxt, un_nxt;

    fp32_div_special u_special (
        .a    (opa),
        .b    (opb),
        .sel  (sel),
        .sign (sign)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state == S_IDLE   ? (start ? S_DIVIDE : S_IDLE) :
                    state == S_DIVIDE ? (cnt == 5'd0 ? S_NORM : S_DIVIDE) : S_IDLE;
    end

    // Trial subtraction: a clear borrow bit means the divisor fits.
    always_comb begin
        diff    = {1'b0, rem} - {3'b0, dvs};
        ge      = ~diff[26];
        rem_sel = ge ? diff[25:0] : rem;
    end

    always_comb begin
        exp_q   = 10'(opa.exp) - 10'(opb.exp) + (q[24] ? 10'(FP32_BIAS) : 10'(FP32_BIAS - 1));
        frac_q  = q[24] ? q[23:1] : q[22:0];
        res_nxt = {sign, exp_q[7:0], frac_q};
        dz_nxt  = 1'b0;
        inv_nxt = 1'b0;
        ov_nxt  = 1'b0;
        un_nxt  = 1'b0;
        case (sel)
            SP_NAN:  begin res_nxt = FP32_QNAN; inv_nxt = 1'b1; end
            SP_DIVZ: begin res_nxt = {sign, FP32_INF_EXP, 23'd0}; dz_nxt = 1'b1; end
            SP_INF:  res_nxt = {sign, FP32_INF_EXP, 23'd0};
            SP_ZERO: res_nxt = {sign, 31'd0};
            default:
                if (exp_q >= 10'sd255) begin
                    res_nxt = {sign, FP32_INF_EXP, 23'd0};
                    ov_nxt  = 1'b1;
                end else if (exp_q <= 10'sd0) begin
                    res_nxt = {sign, 31'd0};
                    un_nxt  = 1'b1;
                end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            opa         <= '0;
            opb         <= '0;
            rem         <= '0;
            dvs         <= '0;
            q           <= '0;
            cnt         <= '0;
            result      <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE:
                    if (start) begin
                        opa  <= a;
                        opb  <= b;
                        dvs  <= {1'b1, b[22:0]};
                        rem  <= {3'b0, 1'b1, a[22:0]};
                        q    <= '0;
                        cnt  <= 5'd24;
                        busy <= 1'b1;
                    end
                S_DIVIDE: begin
                    rem <= rem_sel << 1;
                    q   <= {q[23:0], ge};
                    cnt <= cnt - 5'd1;
                end
                S_NORM: begin
                    result      <= res_nxt;
                    div_by_zero <= dz_nxt;
                    invalid     <= inv_nxt;
                    overflow    <= ov_nxt;
                    underflow   <= un_nxt;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end

endmodule
